hashtable_bm_upd_ctrl: RTL and testbench



---
 rtl/hashtable_cfg_pkg.sv | 26 ++
 rtl/hashtable_bm_upd_ctrl_if.sv | 34 +++
 rtl/hashtable_bm_upd_ctrl.sv | 155 +++++++++++++++
 tb/tb_hashtable_bm_upd_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hashtable_cfg_pkg.sv
// Shared types and default timing constants for the hash-table lookup and its
// bitmap update sequencer.
package hashtable_cfg_pkg;

  typedef enum logic [1:0] {
    OP_SET       = 2'd0,
    OP_CLR       = 2'd1,
    OP_CLEAR_ALL = 2'd2,
    OP_READ      = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StRd,
    StRdWait,
    StWr,
    StClrWr,
    StDone
  } state_e;

  // Must cover hash latency + RAM read + output register of the lookup lanes.
  localparam int unsigned DEF_DRAIN_CYCLES = 6;
  localparam int unsigned DEF_RD_LAT       = 2;

endpackage

// File: rtl/hashtable_bm_upd_ctrl_if.sv
// Command, stall and bitmap-RAM port bundle of the bitmap update sequencer.
// slave = sequencer side, master = control plane / RAM side.
interface hashtable_bm_upd_ctrl_if #(
  parameter int unsigned NBITS = 15
);
  import hashtable_cfg_pkg::*;

  localparam int unsigned BM_AWIDTH = NBITS - 3;

  logic                 cmd_valid;
  logic                 cmd_ready;
  op_e                  cmd_op;
  logic [NBITS-1:0]     cmd_addr;
  logic                 lkp_stall;
  logic [BM_AWIDTH-1:0] bm_addr;
  logic                 bm_rden;
  logic [7:0]           bm_rdata;
  logic                 bm_wren;
  logic [7:0]           bm_wdata;
  logic                 done;
  logic                 rsp_bit;
  logic                 busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, bm_rdata,
    output cmd_ready, lkp_stall, bm_addr, bm_rden, bm_wren, bm_wdata, done, rsp_bit, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, bm_rdata,
    input  cmd_ready, lkp_stall, bm_addr, bm_rden, bm_wren, bm_wdata, done, rsp_bit, busy
  );

endinterface

// File: rtl/hashtable_bm_upd_ctrl.sv
// Stalls the lookup lanes, then applies one bitmap update (set/clear/read a bit,
// or sweep-clear the whole bitmap) through the RAM's write-capable port.
module hashtable_bm_upd_ctrl
  import hashtable_cfg_pkg::*;
#(
  parameter int unsigned NBITS        = 15,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned RD_LAT       = DEF_RD_LAT
) (
  input logic                    clk,
  input logic                    rst_n,
  hashtable_bm_upd_ctrl_if.slave bus
);

  localparam int unsigned BM_AWIDTH = NBITS - 3;
  localparam int unsigned CntMax    = (DRAIN_CYCLES > RD_LAT) ? DRAIN_CYCLES : RD_LAT;
  localparam int unsigned CntW      = $clog2(CntMax + 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [NBITS-1:0]     addr_q, addr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BM_AWIDTH-1:0] ptr_q, ptr_d;
  logic                 stall_q, stall_d;
  logic                 rden_q, rden_d;
  logic                 wren_q, wren_d;
  logic [BM_AWIDTH-1:0] bm_addr_q, bm_addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 rsp_q, rsp_d;
  logic [7:0]           bit_mask;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    stall_d   = stall_q;
    rden_d    = 1'b0;
    wren_d    = 1'b0;
    bm_addr_d = bm_addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    rsp_d     = rsp_q;
    bit_mask  = 8'h01 << addr_q[2:0];

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          addr_d  = bus.cmd_addr;
          stall_d = 1'b1;
          cnt_d   = CntW'(DRAIN_CYCLES - 1);
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          if (op_q == OP_CLEAR_ALL) begin
            ptr_d   = '0;
            state_d = StClrWr;
          end else begin
            rden_d    = 1'b1;
            bm_addr_d = addr_q[NBITS-1:3];
            state_d   = StRd;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRd: begin
        cnt_d   = CntW'(RD_LAT - 1);
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cnt_q == '0) begin
          if (op_q == OP_READ) begin
            rsp_d   = |(bus.bm_rdata & bit_mask);
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            wren_d  = 1'b1;
            wdata_d = (op_q == OP_SET) ? (bus.bm_rdata | bit_mask) : (bus.bm_rdata & ~bit_mask);
            state_d = StWr;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWr: begin
        done_d  = 1'b1;
        state_d = StDone;
      end
      StClrWr: begin
        // Strobes are registered, so each write lands one cycle after its ptr;
        // the final sweep write is on the bus while in StWr.
        wren_d    = 1'b1;
        bm_addr_d = ptr_q;
        wdata_d   = 8'h00;
        if (ptr_q == '1) begin
          state_d = StWr;
        end else begin
          ptr_d = ptr_q + BM_AWIDTH'(1);
        end
      end
      StDone: begin
        stall_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OP_SET;
      addr_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      stall_q   <= 1'b0;
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
      bm_addr_q <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      rsp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      stall_q   <= stall_d;
      rden_q    <= rden_d;
      wren_q    <= wren_d;
      bm_addr_q <= bm_addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      rsp_q     <= rsp_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.lkp_stall = stall_q;
  assign bus.bm_addr   = bm_addr_q;
  assign bus.bm_rden   = rden_q;
  assign bus.bm_wren   = wren_q;
  assign bus.bm_wdata  = wdata_q;
  assign bus.done      = done_q;
  assign bus.rsp_bit   = rsp_q;

endmodule

// File: tb/tb_hashtable_bm_upd_ctrl.sv
// Directed bench for the bitmap update sequencer with a small 8-byte bitmap RAM
// model (NBITS=6) and always-on strobe/stall monitors.
module tb_hashtable_bm_upd_ctrl;
  import hashtable_cfg_pkg::*;

  localparam int unsigned NB = 6;
  localparam int unsigned D  = 6;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hashtable_bm_upd_ctrl_if #(.NBITS(NB)) bus ();

  hashtable_bm_upd_ctrl #(
    .NBITS       (NB),
    .DRAIN_CYCLES(D),
    .RD_LAT      (RL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bitmap RAM model: two-cycle read latency, preload port for the bench.
  logic [7:0] mem [8];
  logic [7:0] rd_s1;
  logic       pre_we;
  logic [2:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.bm_wren) mem[bus.bm_addr] <= bus.bm_wdata;
    if (bus.bm_rden) rd_s1 <= mem[bus.bm_addr];
    bus.bm_rdata <= rd_s1;
  end

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  int stall_run = 0;
  bit strobed   = 1'b0;
  int done_cnt  = 0;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.bm_rden || bus.bm_wren) begin
      check_eq("rw_excl", 32'(bus.bm_rden & bus.bm_wren), 32'd0);
      check_eq("strobe_stall", 32'(bus.lkp_stall), 32'd1);
    end
    if (bus.lkp_stall) begin
      if ((bus.bm_rden || bus.bm_wren) && !strobed) begin
        check_eq("stall_lead", 32'(stall_run >= int'(D)), 32'd1);
        strobed = 1'b1;
      end
      stall_run++;
    end else begin
      stall_run = 0;
      strobed   = 1'b0;
    end
  end

  int         wr_n, rd_n, rd_cy, done_at;
  int         wr_cy [16];
  logic [2:0] wr_ad [16];
  logic [7:0] wr_dt [16];
  logic [2:0] rd_ad;
  logic [7:0] rdata_cap;
  bit         rdy_hi_seen;

  // Cycle k = k-th negedge after the accepting posedge.
  task automatic run_cmd(input op_e op, input logic [NB-1:0] addr, input bit hold,
                         input op_e nop, input logic [NB-1:0] naddr);
    wr_n = 0; rd_n = 0; rd_cy = -1; done_at = -1; rdy_hi_seen = 1'b0; rdata_cap = 8'h00;
    rd_ad = 3'd0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    @(negedge clk);
    check_eq("accept_rdy", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    if (hold) begin
      bus.cmd_op   = nop;
      bus.cmd_addr = naddr;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("stall_rise", 32'(bus.lkp_stall), 32'd1);
      if (bus.cmd_ready) rdy_hi_seen = 1'b1;
      if (bus.bm_rden) begin
        rd_n++;
        rd_cy = k;
        rd_ad = bus.bm_addr;
      end
      if (rd_cy > 0 && k == rd_cy + int'(RL)) rdata_cap = bus.bm_rdata;
      if (bus.bm_wren && wr_n < 16) begin
        wr_cy[wr_n] = k;
        wr_ad[wr_n] = bus.bm_addr;
        wr_dt[wr_n] = bus.bm_wdata;
        wr_n++;
      end
      if (bus.done) begin
        done_at = k;
        break;
      end
    end
    check_eq("done_seen", 32'(done_at > 0), 32'd1);
    check_eq("rdy_low_busy", 32'(rdy_hi_seen), 32'd0);
  endtask

  bit   found;
  int   d0;
  logic [7:0] acc;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_SET;
    bus.cmd_addr  = '0;
    pre_we = 1'b0; pre_addr = 3'd0; pre_data = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", 32'(bus.lkp_stall), 32'd0);
    check_eq("rst_rden", 32'(bus.bm_rden), 32'd0);
    check_eq("rst_wren", 32'(bus.bm_wren), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_addr", 32'(bus.bm_addr), 32'd0);
    check_eq("rst_wdata", 32'(bus.bm_wdata), 32'd0);
    for (int i = 0; i < 8; i++) preload(3'(i), 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("rst_ready", 32'(bus.cmd_ready), 32'd1);

    // SET 0x13 -> byte 2, bit 3
    run_cmd(OP_SET, 6'h13, 1'b0, OP_SET, 6'h00);
    check_eq("set_rd_n", 32'(rd_n), 32'd1);
    check_eq("set_rd_cy", 32'(rd_cy), 32'(D + 1));
    check_eq("set_rd_ad", 32'(rd_ad), 32'd2);
    check_eq("set_wr_n", 32'(wr_n), 32'd1);
    check_eq("set_wr_ad", 32'(wr_ad[0]), 32'd2);
    check_eq("set_wr_dt", 32'(wr_dt[0]), 32'h08);
    check_eq("set_wr_cy", 32'(wr_cy[0]), 32'(D + RL + 2));
    check_eq("set_done", 32'(done_at), 32'(D + RL + 3));
    @(posedge clk);
    #1;
    check_eq("stall_drop", 32'(bus.lkp_stall), 32'd0);
    check_eq("ready_back", 32'(bus.cmd_ready), 32'd1);

    // CLR 0x17 on 0xFF -> 0x7F, then READ bits 7 and 6
    preload(3'd2, 8'hFF);
    run_cmd(OP_CLR, 6'h17, 1'b0, OP_SET, 6'h00);
    check_eq("clr_wr_dt", 32'(wr_dt[0]), 32'h7F);
    check_eq("clr_done", 32'(done_at), 32'(D + RL + 3));
    run_cmd(OP_READ, 6'h17, 1'b0, OP_SET, 6'h00);
    check_eq("rd17_done", 32'(done_at), 32'(D + RL + 2));
    check_eq("rd17_wr_n", 32'(wr_n), 32'd0);
    check_eq("rd17_bit", 32'(bus.rsp_bit), 32'd0);
    run_cmd(OP_READ, 6'h16, 1'b0, OP_SET, 6'h00);
    check_eq("rd16_bit", 32'(bus.rsp_bit), 32'd1);
    @(posedge clk);
    #1 check_eq("rd16_hold", 32'(bus.rsp_bit), 32'd1);

    // CLEAR_ALL: 8 writes to 0..7, done right after the last
    run_cmd(OP_CLEAR_ALL, 6'h3F, 1'b0, OP_SET, 6'h00);
    check_eq("ca_wr_n", 32'(wr_n), 32'd8);
    check_eq("ca_rd_n", 32'(rd_n), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_eq("ca_wr_ad", 32'(wr_ad[i]), 32'(i));
      check_eq("ca_wr_dt", 32'(wr_dt[i]), 32'd0);
      check_eq("ca_wr_cy", 32'(wr_cy[i]), 32'(D + 2 + i));
    end
    check_eq("ca_done", 32'(done_at), 32'(D + 8 + 2));
    acc = 8'h00;
    for (int i = 0; i < 8; i++) acc = acc | mem[i];
    check_eq("ca_mem_zero", 32'(acc), 32'd0);

    // Back-to-back SET 0x01 then 0x02 with valid held high
    run_cmd(OP_SET, 6'h01, 1'b1, OP_SET, 6'h02);
    check_eq("b2b1_wr_dt", 32'(wr_dt[0]), 32'h02);
    check_eq("b2b1_done", 32'(done_at), 32'(D + RL + 3));
    run_cmd(OP_SET, 6'h02, 1'b0, OP_SET, 6'h00);
    check_eq("b2b2_rdata", 32'(rdata_cap), 32'h02);
    check_eq("b2b2_wr_ad", 32'(wr_ad[0]), 32'd0);
    check_eq("b2b2_wr_dt", 32'(wr_dt[0]), 32'h06);

    // Reset in the middle of a CLEAR_ALL sweep
    preload(3'd5, 8'hAA);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_CLEAR_ALL;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.bm_wren && bus.bm_addr == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("ptr3_reached", 32'(found), 32'd1);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_stall", 32'(bus.lkp_stall), 32'd0);
    check_eq("mid_wren", 32'(bus.bm_wren), 32'd0);
    check_eq("mid_rden", 32'(bus.bm_rden), 32'd0);
    check_eq("mid_done", 32'(bus.done), 32'd0);
    check_eq("mid_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rsp", 32'(bus.rsp_bit), 32'd0);
    check_eq("mid_addr", 32'(bus.bm_addr), 32'd0);
    check_eq("mid_wdata", 32'(bus.bm_wdata), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("post_busy", 32'(bus.busy), 32'd0);
    check_eq("no_done_pulse", 32'(done_cnt), 32'(d0));
    check_eq("partial_mem5", 32'(mem[5]), 32'hAA);

    // Recovery: READ byte 5 bit 1 (0xAA)
    run_cmd(OP_READ, 6'h29, 1'b0, OP_SET, 6'h00);
    check_eq("rec_bit", 32'(bus.rsp_bit), 32'd1);
    check_eq("rec_done", 32'(done_at), 32'(D + RL + 2));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
